// File: rtl/io_arbiter_pkg.sv
// Shared types for the IO bus arbiter: bus word and arbiter FSM states.
package io_arbiter_pkg;

  localparam int unsigned SCALAR_W = 32;

  typedef logic [SCALAR_W-1:0] scalar_t;

  typedef enum logic [1:0] {
    IO_ARB_IDLE,
    IO_ARB_ISSUE,
    IO_ARB_WAIT
  } io_arbiter_state_t;

endpackage

// File: rtl/io_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, pointer advances
// past the winner only when update_en is set and a grant is made.
module rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQUESTERS-1:0]         request,
  input  logic                              update_en,
  output logic [NUM_REQUESTERS-1:0]         grant,
  output logic [$clog2(NUM_REQUESTERS)-1:0] grant_idx,
  output logic                              grant_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [SUM_W-1:0] cand;

  // Scan from the pointer upward, wrapping, and take the first request seen.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, ptr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQUESTERS))
        cand = cand - SUM_W'(NUM_REQUESTERS);
      if (!grant_valid && request[cand[IDX_W-1:0]]) begin
        grant_valid                = 1'b1;
        grant_idx                  = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (update_en && grant_valid)
      ptr <= (grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

endmodule

// File: rtl/io_arbiter.sv
// Shares the single-master IO bus between several requesters, one
// transaction at a time, with fixed-latency read return.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  input  logic [NUM_REQUESTERS-1:0] req_write,
  input  scalar_t                   req_address    [NUM_REQUESTERS],
  input  scalar_t                   req_write_data [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] req_ack,
  output logic [NUM_REQUESTERS-1:0] resp_valid,
  output scalar_t                   resp_data,
  output logic                      io_write_en,
  output logic                      io_read_en,
  output scalar_t                   io_address,
  output scalar_t                   io_write_data,
  input  scalar_t                   io_read_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);
  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

  io_arbiter_state_t         state;
  logic [IDX_W-1:0]          cur_idx;
  logic                      cur_write;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_valid;
  logic                      arb_en;

  // Grants are only offered from IDLE and never while reset is held.
  assign arb_en  = (state == IO_ARB_IDLE) && !reset;
  assign req_ack = arb_en ? grant : '0;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr (
    .clk        (clk),
    .reset      (reset),
    .request    (req_valid),
    .update_en  (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IO_ARB_IDLE;
      cur_idx       <= '0;
      cur_write     <= 1'b0;
      cnt           <= '0;
      io_write_en   <= 1'b0;
      io_read_en    <= 1'b0;
      io_address    <= '0;
      io_write_data <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
    end else begin
      io_write_en <= 1'b0;
      io_read_en  <= 1'b0;
      resp_valid  <= '0;
      case (state)
        IO_ARB_IDLE: begin
          if (grant_valid) begin
            cur_idx       <= grant_idx;
            cur_write     <= req_write[grant_idx];
            io_address    <= req_address[grant_idx];
            io_write_data <= req_write_data[grant_idx];
            io_write_en   <= req_write[grant_idx];
            io_read_en    <= !req_write[grant_idx];
            state         <= IO_ARB_ISSUE;
          end
        end
        IO_ARB_ISSUE: begin
          if (cur_write) begin
            state <= IO_ARB_IDLE;
          end else begin
            cnt   <= CNT_W'(READ_LATENCY);
            state <= IO_ARB_WAIT;
          end
        end
        IO_ARB_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Final wait cycle: bus data is valid now, response goes out next cycle.
          if (cnt == CNT_W'(1)) begin
            resp_data           <= io_read_data;
            resp_valid[cur_idx] <= 1'b1;
            state               <= IO_ARB_IDLE;
          end
        end
        default: state <= IO_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: a READ_LATENCY=1 instance for most scenarios
// and a READ_LATENCY=3 instance for the long-latency read.
module tb_io_arbiter;
  import io_arbiter_pkg::*;

  logic    clk;
  logic    reset;
  int      vectors;
  int      miscompares;

  logic [3:0] req_valid, req_write, req_ack, resp_valid;
  scalar_t    req_address [4];
  scalar_t    req_write_data [4];
  scalar_t    resp_data, io_address, io_write_data, io_read_data, rdata1;
  logic       io_write_en, io_read_en, rd_d1;

  logic [3:0] req_valid3, req_write3, req_ack3, resp_valid3;
  scalar_t    req_address3 [4];
  scalar_t    req_write_data3 [4];
  scalar_t    resp_data3, io_address3, io_write_data3, io_read_data3, rdata3;
  logic       io_write_en3, io_read_en3;
  logic [2:0] rd_pipe3;

  io_arbiter #(.NUM_REQUESTERS(4), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
    .io_write_data(io_write_data), .io_read_data(io_read_data)
  );

  io_arbiter #(.NUM_REQUESTERS(4), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_write(req_write3),
    .req_address(req_address3), .req_write_data(req_write_data3),
    .req_ack(req_ack3), .resp_valid(resp_valid3), .resp_data(resp_data3),
    .io_write_en(io_write_en3), .io_read_en(io_read_en3), .io_address(io_address3),
    .io_write_data(io_write_data3), .io_read_data(io_read_data3)
  );

  always #5 clk = ~clk;

  // Peripheral models: data is driven exactly READ_LATENCY cycles after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1    <= 1'b0;
      rd_pipe3 <= '0;
    end else begin
      rd_d1    <= io_read_en;
      rd_pipe3 <= {rd_pipe3[1:0], io_read_en3};
    end
  end
  assign io_read_data  = rd_d1 ? rdata1 : 32'h0;
  assign io_read_data3 = rd_pipe3[2] ? rdata3 : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    req_valid = 4'hF;
    #1;
    vectors++; if (req_ack !== 4'h0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
    vectors++; if (io_write_en !== 1'b0 || io_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got we=%b re=%b expected 0 0", io_write_en, io_read_en); end
    vectors++; if (resp_valid !== 4'h0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    vectors++; if (io_address !== 32'h0 || io_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", io_address, io_write_data); end
    vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    for (int i = 0; i < 4; i++) begin
      req_address[i]    = 32'h100 + 32'(i * 16);
      req_write_data[i] = 32'hA0 + 32'(i);
    end
    req_write = 4'hF;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) reset = 1'b0;
      req_valid = (c < 9) ? 4'hF : 4'h0;
      #1;
      exp_ack = (c % 2 == 0 && c < 9) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
      vectors++; if (req_ack !== exp_ack) begin miscompares++; $display("FAIL rr_ack cycle %0d: got %b expected %b", c, req_ack, exp_ack); end
      if (c % 2 == 1) begin
        vectors++; if (io_write_en !== 1'b1 || io_address !== 32'h100 + 32'(((c / 2) % 4) * 16)) begin miscompares++; $display("FAIL rr_bus cycle %0d: got we=%b addr=%h expected 1 %h", c, io_write_en, io_address, 32'h100 + 32'(((c / 2) % 4) * 16)); end
      end else begin
        vectors++; if (io_write_en !== 1'b0) begin miscompares++; $display("FAIL rr_idle_strobe cycle %0d: got %b expected 0", c, io_write_en); end
      end
    end
  endtask

  task automatic test_single_write();
    step();
    req_valid = 4'b0010; req_write = 4'b0010;
    req_address[1] = 32'h04; req_write_data[1] = 32'h1A5;
    #1;
    vectors++; if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL wr_ack: got %b expected 0010", req_ack); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (io_write_en !== 1'b1 || io_read_en !== 1'b0) begin miscompares++; $display("FAIL wr_strobe: got we=%b re=%b expected 1 0", io_write_en, io_read_en); end
    vectors++; if (io_address !== 32'h04 || io_write_data !== 32'h1A5) begin miscompares++; $display("FAIL wr_bus: got addr=%h wdata=%h expected 4 1a5", io_address, io_write_data); end
    vectors++; if (req_ack !== 4'h0) begin miscompares++; $display("FAIL wr_issue_ack: got %b expected 0000", req_ack); end
    step();
    #1;
    vectors++; if (io_write_en !== 1'b0 || resp_valid !== 4'h0) begin miscompares++; $display("FAIL wr_after: got we=%b rv=%b expected 0 0000", io_write_en, resp_valid); end
    vectors++; if (io_address !== 32'h04) begin miscompares++; $display("FAIL wr_addr_hold: got %h expected 4", io_address); end
  endtask

  task automatic test_read();
    step();
    req_valid = 4'b0100; req_write = 4'b0000; req_address[2] = 32'h2C; rdata1 = 32'h1;
    #1;
    vectors++; if (req_ack !== 4'b0100) begin miscompares++; $display("FAIL rd_ack: got %b expected 0100", req_ack); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (io_read_en !== 1'b1 || io_write_en !== 1'b0 || io_address !== 32'h2C) begin miscompares++; $display("FAIL rd_strobe: got re=%b we=%b addr=%h expected 1 0 2c", io_read_en, io_write_en, io_address); end
    step();
    #1;
    vectors++; if (io_read_en !== 1'b0 || resp_valid !== 4'h0) begin miscompares++; $display("FAIL rd_wait: got re=%b rv=%b expected 0 0000", io_read_en, resp_valid); end
    step();
    #1;
    vectors++; if (resp_valid !== 4'b0100 || resp_data !== 32'h1) begin miscompares++; $display("FAIL rd_resp: got rv=%b data=%h expected 0100 1", resp_valid, resp_data); end
    step();
    #1;
    vectors++; if (resp_valid !== 4'h0 || resp_data !== 32'h1) begin miscompares++; $display("FAIL rd_resp_hold: got rv=%b data=%h expected 0000 1", resp_valid, resp_data); end
  endtask

  task automatic test_withdrawal();
    step();
    req_valid = 4'b0001; req_write = 4'b0001; req_address[0] = 32'h10; req_write_data[0] = 32'h77;
    #1;
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL wd_ack0: got %b expected 0001", req_ack); end
    step();
    req_valid = 4'b1000; req_write = 4'b1000; req_address[3] = 32'h30;
    #1;
    vectors++; if (req_ack !== 4'h0 || io_write_en !== 1'b1 || io_address !== 32'h10) begin miscompares++; $display("FAIL wd_issue: got ack=%b we=%b addr=%h expected 0000 1 10", req_ack, io_write_en, io_address); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (req_ack !== 4'h0 || io_write_en !== 1'b0 || io_read_en !== 1'b0) begin miscompares++; $display("FAIL wd_drop: got ack=%b we=%b re=%b expected 0000 0 0", req_ack, io_write_en, io_read_en); end
    step();
    #1;
    vectors++; if (req_ack !== 4'h0 || io_write_en !== 1'b0 || io_read_en !== 1'b0) begin miscompares++; $display("FAIL wd_no_cycle: got ack=%b we=%b re=%b expected 0000 0 0", req_ack, io_write_en, io_read_en); end
  endtask

  task automatic test_reset_mid_read();
    step();
    req_valid = 4'b0001; req_write = 4'b0000; req_address[0] = 32'h40; rdata1 = 32'h99;
    #1;
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL rmr_ack: got %b expected 0001", req_ack); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (io_read_en !== 1'b1) begin miscompares++; $display("FAIL rmr_strobe: got %b expected 1", io_read_en); end
    step();
    reset = 1'b1;
    #1;
    vectors++; if (req_ack !== 4'h0) begin miscompares++; $display("FAIL rmr_reset_ack: got %b expected 0000", req_ack); end
    step();
    reset = 1'b0;
    req_valid = 4'b0011; req_write = 4'b0000;
    req_address[0] = 32'h44; req_address[1] = 32'h48; rdata1 = 32'h55;
    #1;
    vectors++; if (resp_valid !== 4'h0 || io_read_en !== 1'b0 || io_write_en !== 1'b0) begin miscompares++; $display("FAIL rmr_dropped: got rv=%b re=%b we=%b expected 0000 0 0", resp_valid, io_read_en, io_write_en); end
    vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL rmr_resp_data: got %h expected 0", resp_data); end
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL rmr_ptr0: got %b expected 0001", req_ack); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (io_read_en !== 1'b1 || io_address !== 32'h44) begin miscompares++; $display("FAIL rmr_reissue: got re=%b addr=%h expected 1 44", io_read_en, io_address); end
    step();
    #1;
    vectors++; if (resp_valid !== 4'h0) begin miscompares++; $display("FAIL rmr_wait: got %b expected 0000", resp_valid); end
    step();
    req_valid = 4'b0001; req_write = 4'b0001; req_address[0] = 32'h50; req_write_data[0] = 32'h5A;
    #1;
    vectors++; if (resp_valid !== 4'b0001 || resp_data !== 32'h55) begin miscompares++; $display("FAIL rmr_resp: got rv=%b data=%h expected 0001 55", resp_valid, resp_data); end
    vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL b2b_ack: got %b expected 0001", req_ack); end
    step();
    req_valid = 4'h0;
    #1;
    vectors++; if (io_write_en !== 1'b1 || io_address !== 32'h50 || io_write_data !== 32'h5A || resp_valid !== 4'h0) begin miscompares++; $display("FAIL b2b_write: got we=%b addr=%h wdata=%h rv=%b expected 1 50 5a 0000", io_write_en, io_address, io_write_data, resp_valid); end
  endtask

  task automatic test_latency3();
    step();
    req_valid3 = 4'b0001; req_write3 = 4'b0000; req_address3[0] = 32'h80; rdata3 = 32'hDEADBEEF;
    #1;
    vectors++; if (req_ack3 !== 4'b0001) begin miscompares++; $display("FAIL l3_ack: got %b expected 0001", req_ack3); end
    step();
    req_valid3 = 4'h0;
    #1;
    vectors++; if (io_read_en3 !== 1'b1 || io_address3 !== 32'h80) begin miscompares++; $display("FAIL l3_strobe: got re=%b addr=%h expected 1 80", io_read_en3, io_address3); end
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      vectors++; if (resp_valid3 !== 4'h0 || io_read_en3 !== 1'b0) begin miscompares++; $display("FAIL l3_wait %0d: got rv=%b re=%b expected 0000 0", k, resp_valid3, io_read_en3); end
    end
    vectors++; if (resp_data3 !== 32'h0) begin miscompares++; $display("FAIL l3_early_data: got %h expected 0", resp_data3); end
    step();
    #1;
    vectors++; if (resp_valid3 !== 4'b0001 || resp_data3 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL l3_resp: got rv=%b data=%h expected 0001 deadbeef", resp_valid3, resp_data3); end
    step();
    #1;
    vectors++; if (resp_valid3 !== 4'h0) begin miscompares++; $display("FAIL l3_resp_pulse: got %b expected 0000", resp_valid3); end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    vectors = 0;
    miscompares = 0;
    req_valid = '0; req_write = '0; req_valid3 = '0; req_write3 = '0;
    rdata1 = '0; rdata3 = '0;
    for (int i = 0; i < 4; i++) begin
      req_address[i] = '0; req_write_data[i] = '0;
      req_address3[i] = '0; req_write_data3[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_single_write();
    test_read();
    test_withdrawal();
    test_reset_mid_read();
    test_latency3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
